rect_chain_programmer: RTL and testbench

- Sits at the head of the rect_renderer chain.
- Accepts whole-shape programming commands from the host side and serialises them into five programming beats (reg IDs 0..4).
- Merges those beats into the pixel stream, injecting them only in blanking cycles with no pixel present.
- Drives the program/x/y/data inputs of renderer stage 0. Shape index N is addressed by hop count N; each stage decrements x, and the stage that sees x==0 captures the beat.

---
 rtl/rect_ctrl_pkg.sv | 40 ++++
 rtl/rect_shadow_regs.sv | 60 ++++++
 rtl/rect_chain_programmer.sv | 167 ++++++++++++++++
 tb/tb_rect_chain_programmer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_ctrl_pkg.sv
// rect_ctrl_pkg: shared widths, register IDs, FSM encoding and helpers for the
// rect_renderer chain programmer.
package rect_ctrl_pkg;

   localparam int X_W      = 11;
   localparam int Y_W      = 12;
   localparam int COLOR_W  = 12;

   localparam int REG_XCOORD = 0;
   localparam int REG_YCOORD = 1;
   localparam int REG_WIDTH  = 2;
   localparam int REG_HEIGHT = 3;
   localparam int REG_COLOR  = 4;
   localparam int NUM_REGS   = 5;
   localparam int REG_ID_W   = 3;

   localparam logic [COLOR_W-1:0] DEFAULT_COLOR = 12'hFFF;

   // One whole shape: five 12-bit fields, indexed by register ID.
   typedef logic [NUM_REGS-1:0][COLOR_W-1:0] field_vec_t;

   // Renderer power-up contents: zero geometry, white colour.
   localparam field_vec_t SHADOW_RESET = {DEFAULT_COLOR, {((NUM_REGS-1)*COLOR_W){1'b0}}};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Lowest set bit of a pending-beat mask; beats go out in register-ID order.
   function automatic logic [REG_ID_W-1:0] first_set(input logic [NUM_REGS-1:0] mask);
      logic [REG_ID_W-1:0] idx;
      idx = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (mask[i]) idx = REG_ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rect_shadow_regs.sv
// rect_shadow_regs: per-shape copy of what the renderer chain currently holds,
// plus a field-by-field compare against an incoming command.
// Only instantiated when RECT_SHADOW_EN is defined.
module rect_shadow_regs
   import rect_ctrl_pkg::*;
#(
   parameter int NUM_SHAPES = 8,
   parameter int SHAPE_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SHAPE_W-1:0]  rd_shape,
   input  field_vec_t          rd_fields,
   output logic [NUM_REGS-1:0] diff_mask,
   input  logic                wr_en,
   input  logic [SHAPE_W-1:0]  wr_shape,
   input  logic [REG_ID_W-1:0] wr_reg,
   input  logic [COLOR_W-1:0]  wr_data
);

   field_vec_t row_w [NUM_SHAPES];
   field_vec_t rd_row;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SHAPES; gi++) begin : g_shape
         localparam logic [SHAPE_W-1:0] IDX = SHAPE_W'(gi);
         field_vec_t row_q, row_d;

         // Overwrite one field of this shape when its beat goes out.
         always_comb begin
            row_d = row_q;
            if (wr_en && (wr_shape == IDX)) row_d[wr_reg] = wr_data;
         end

         // Shadow row register, back to renderer defaults on reset.
         always_ff @(posedge clk) begin
            if (rst) row_q <= SHADOW_RESET;
            else     row_q <= row_d;
         end

         assign row_w[gi] = row_q;
      end
   endgenerate

   // Select the addressed row; out-of-range indices read as defaults (unused).
   always_comb begin
      rd_row = SHADOW_RESET;
      for (int s = 0; s < NUM_SHAPES; s++) begin
         if (int'(rd_shape) == s) rd_row = row_w[s];
      end
   end

   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_diff
         assign diff_mask[gi] = (rd_fields[gi] != rd_row[gi]);
      end
   endgenerate

endmodule

// File: rtl/rect_chain_programmer.sv
// rect_chain_programmer: turns whole-shape commands into five programming
// beats and merges them into the pixel stream during blanking.
// Build option: RECT_SHADOW_EN skips beats whose value the shape already holds.
module rect_chain_programmer
   import rect_ctrl_pkg::*;
#(
   parameter int NUM_SHAPES = 8,
   parameter int SHAPE_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SHAPE_W-1:0] cmd_shape,
   input  logic [10:0]        cmd_xcoord,
   input  logic [11:0]        cmd_ycoord,
   input  logic [10:0]        cmd_width,
   input  logic [11:0]        cmd_height,
   input  logic [11:0]        cmd_color,
   input  logic               pix_valid,
   input  logic [10:0]        pix_x,
   input  logic [11:0]        pix_y,
   input  logic [11:0]        pix_data,
   input  logic               blank,
   output logic               program_out,
   output logic [10:0]        x_out,
   output logic [11:0]        y_out,
   output logic [11:0]        data_out,
   output logic               busy,
   output logic               bad_cmd
);

   state_t                state_q, state_d;
   logic [SHAPE_W-1:0]    shape_q, shape_d;
   field_vec_t            fields_q, fields_d;
   logic [NUM_REGS-1:0]   pending_q, pending_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  bad_cmd_q, bad_cmd_d;
   logic                  program_q, program_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic [COLOR_W-1:0]    data_q, data_d;

   field_vec_t            cmd_fields;
   logic [NUM_REGS-1:0]   diff_mask;
   logic                  shape_ok;
   logic [REG_ID_W-1:0]   beat_idx;
   logic                  beat_fire;

   // Command fields packed by register ID, 11-bit ones zero-extended.
   always_comb begin
      cmd_fields             = '0;
      cmd_fields[REG_XCOORD] = {1'b0, cmd_xcoord};
      cmd_fields[REG_YCOORD] = cmd_ycoord;
      cmd_fields[REG_WIDTH]  = {1'b0, cmd_width};
      cmd_fields[REG_HEIGHT] = cmd_height;
      cmd_fields[REG_COLOR]  = cmd_color;
   end

   assign shape_ok  = (int'(cmd_shape) < NUM_SHAPES);
   assign beat_idx  = first_set(pending_q);
   // A beat may only use a blanking slot that no pixel occupies.
   assign beat_fire = (state_q == ST_SEND) && (pending_q != '0) && blank && !pix_valid;

`ifdef RECT_SHADOW_EN
   rect_shadow_regs #(
      .NUM_SHAPES (NUM_SHAPES),
      .SHAPE_W    (SHAPE_W)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .rd_shape  (cmd_shape),
      .rd_fields (cmd_fields),
      .diff_mask (diff_mask),
      .wr_en     (beat_fire),
      .wr_shape  (shape_q),
      .wr_reg    (beat_idx),
      .wr_data   (fields_q[beat_idx])
   );
`else
   assign diff_mask = '1;
`endif

   // Next-state, beat scheduling and output mux (pixel pass-through by default).
   always_comb begin
      state_d   = state_q;
      shape_d   = shape_q;
      fields_d  = fields_q;
      pending_d = pending_q;
      bad_cmd_d = 1'b0;
      program_d = 1'b0;
      x_d       = pix_x;
      y_d       = pix_y;
      data_d    = pix_valid ? pix_data : '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (!shape_ok) begin
                  bad_cmd_d = 1'b1;
               end else begin
                  shape_d   = cmd_shape;
                  fields_d  = cmd_fields;
                  pending_d = diff_mask;
                  state_d   = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (pending_q == '0) begin
               // Nothing differed from the shadow: finish without any beat.
               state_d = ST_IDLE;
            end else if (beat_fire) begin
               program_d           = 1'b1;
               x_d                 = X_W'(shape_q);
               y_d                 = Y_W'(beat_idx);
               data_d              = fields_q[beat_idx];
               pending_d[beat_idx] = 1'b0;
               if (pending_d == '0) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d == ST_SEND);
   end

   // All state and outputs registered; everything clears on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shape_q     <= '0;
         fields_q    <= '0;
         pending_q   <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         bad_cmd_q   <= 1'b0;
         program_q   <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         shape_q     <= shape_d;
         fields_q    <= fields_d;
         pending_q   <= pending_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         bad_cmd_q   <= bad_cmd_d;
         program_q   <= program_d;
         x_q         <= x_d;
         y_q         <= y_d;
         data_q      <= data_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign busy        = busy_q;
   assign bad_cmd     = bad_cmd_q;
   assign program_out = program_q;
   assign x_out       = x_q;
   assign y_out       = y_q;
   assign data_out    = data_q;

endmodule

// File: tb/tb_rect_chain_programmer.sv
// tb_rect_chain_programmer: scoreboard bench. The driver keeps a queue-based
// model of pending beats and pushes expected beats/pixels; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_rect_chain_programmer;
   import rect_ctrl_pkg::*;

   localparam int NS = 6;
   localparam int SW = 3;
`ifdef RECT_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [SW-1:0] cmd_shape = '0;
   logic [10:0]   cmd_xcoord = '0;
   logic [11:0]   cmd_ycoord = '0;
   logic [10:0]   cmd_width = '0;
   logic [11:0]   cmd_height = '0;
   logic [11:0]   cmd_color = '0;
   logic          pix_valid = 1'b0;
   logic [10:0]   pix_x = '0;
   logic [11:0]   pix_y = '0;
   logic [11:0]   pix_data = '0;
   logic          blank = 1'b1;
   logic          program_out;
   logic [10:0]   x_out;
   logic [11:0]   y_out;
   logic [11:0]   data_out;
   logic          busy;
   logic          bad_cmd;

   always #5 clk = ~clk;

   rect_chain_programmer #(.NUM_SHAPES(NS), .SHAPE_W(SW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_shape(cmd_shape), .cmd_xcoord(cmd_xcoord), .cmd_ycoord(cmd_ycoord),
      .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_color(cmd_color),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .blank(blank), .program_out(program_out), .x_out(x_out), .y_out(y_out),
      .data_out(data_out), .busy(busy), .bad_cmd(bad_cmd)
   );

   typedef struct { int shape; int k; int data; int cyc; } beat_t;
   typedef struct { int x; int y; int data; } pix_t;

   beat_t beat_q[$];
   pix_t  pix_q[$];
   int    pend_k[$];
   int    cur_shape;
   int    cur_f[5];
   int    shadow[NS][5];
   bit    m_send;
   bit    exp_ready, exp_busy, exp_bad;
   int    exp_kind;             // 0 idle, 1 pixel, 2 beat
   int    exp_px, exp_py;
   bit    acc_evt, bad_evt;
   int    cyc, checks, failures;
   int    beats_issued, dut_beats, last_beat_y;
   bit    mon_en;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
      end
   endtask

   function automatic void reset_shadow();
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < 4; k++) shadow[s][k] = 0;
         shadow[s][4] = 'hFFF;
      end
   endfunction

   // Reference model: what the DUT must show after the edge just taken.
   function automatic void model();
      bit issued;
      int k;
      int f[5];
      issued  = 1'b0;
      exp_bad = 1'b0;
      exp_kind = 0;
      acc_evt = 1'b0;
      bad_evt = 1'b0;
      if (rst) begin
         pend_k.delete();
         m_send = 1'b0;
         exp_ready = 1'b0;
         exp_busy = 1'b0;
         exp_px = 0;
         exp_py = 0;
         reset_shadow();
         return;
      end
      if (m_send) begin
         if (pend_k.size() == 0) begin
            m_send = 1'b0;
         end else if (blank && !pix_valid) begin
            k = pend_k.pop_front();
            beat_q.push_back('{cur_shape, k, cur_f[k], cyc});
            shadow[cur_shape][k] = cur_f[k];
            issued = 1'b1;
            beats_issued++;
            if (pend_k.size() == 0) m_send = 1'b0;
         end
      end else if (cmd_valid && exp_ready) begin
         if (int'(cmd_shape) >= NS) begin
            exp_bad = 1'b1;
            bad_evt = 1'b1;
         end else begin
            f = '{int'(cmd_xcoord), int'(cmd_ycoord), int'(cmd_width),
                  int'(cmd_height), int'(cmd_color)};
            cur_shape = int'(cmd_shape);
            cur_f = f;
            for (int r = 0; r < 5; r++) begin
               if (!SHADOW || f[r] != shadow[cur_shape][r]) pend_k.push_back(r);
            end
            m_send = 1'b1;
            acc_evt = 1'b1;
         end
      end
      if (issued) begin
         exp_kind = 2;
      end else begin
         exp_px = int'(pix_x);
         exp_py = int'(pix_y);
         if (pix_valid) begin
            exp_kind = 1;
            pix_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_data)});
         end
      end
      exp_ready = !m_send;
      exp_busy  = m_send;
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      model();
      #2;
      mon_en = 1'b1;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_cmd(int s, int xc, int yc, int w, int h, int c);
      bit done;
      cmd_shape  = SW'(s);
      cmd_xcoord = 11'(xc);
      cmd_ycoord = 12'(yc);
      cmd_width  = 11'(w);
      cmd_height = 12'(h);
      cmd_color  = 12'(c);
      cmd_valid  = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         done = acc_evt || bad_evt;
      end
      chk("cmd_handshake", int'(done), 1);
      cmd_valid = 1'b0;
      $display("cmd shape=%0d x=%0d y=%0d w=%0d h=%0d c=%03h bad=%0d cycle=%0d",
               s, xc, yc, w, h, c, bad_evt, cyc);
   endtask

   task automatic wait_beats(int target);
      for (int i = 0; i < 200 && beats_issued < target; i++) step();
      chk("wait_beats", int'(beats_issued >= target), 1);
   endtask

   // Monitor: pop and compare whatever the DUT presents this cycle.
   initial begin
      beat_t b;
      pix_t  p;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
            chk("busy", int'(busy), int'(exp_busy));
            chk("bad_cmd", int'(bad_cmd), int'(exp_bad));
            chk("program_out", int'(program_out), int'(exp_kind == 2));
            if (program_out) begin
               dut_beats++;
               last_beat_y = int'(y_out);
               chk("beat_expected", int'(beat_q.size() > 0), 1);
               if (beat_q.size() > 0) begin
                  b = beat_q.pop_front();
                  chk("beat_x", int'(x_out), b.shape);
                  chk("beat_y", int'(y_out), b.k);
                  chk("beat_data", int'(data_out), b.data);
                  chk("beat_cycle", cyc, b.cyc);
               end
               $display("beat x=%0d y=%0d data=%03h cycle=%0d", x_out, y_out, data_out, cyc);
            end else if (exp_kind == 1) begin
               chk("pix_expected", int'(pix_q.size() > 0), 1);
               if (pix_q.size() > 0) begin
                  p = pix_q.pop_front();
                  chk("pix_x", int'(x_out), p.x);
                  chk("pix_y", int'(y_out), p.y);
                  chk("pix_data", int'(data_out), p.data);
               end
            end else begin
               chk("idle_x", int'(x_out), exp_px);
               chk("idle_y", int'(y_out), exp_py);
               chk("idle_data", int'(data_out), 0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int rf[5];
      int rs;
      reset_shadow();
      rs = 0;
      rf = '{0, 0, 0, 0, 0};

      // Reset, then release with blanking and no pixels.
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(2);

      // Idle programming: five back-to-back beats.
      base = dut_beats;
      send_cmd(2, 10, 20, 30, 40, 'hF00);
      run(8);
      chk("idle_prog_count", dut_beats - base, 5);

      // Pixel priority: three pixels right after accept.
      send_cmd(3, 100, 200, 300, 400, 'h0F0);
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1;
         pix_x = 11'($urandom_range(0, 2047));
         pix_y = 12'($urandom_range(0, 4095));
         pix_data = 12'($urandom_range(0, 4095));
         step();
      end
      pix_valid = 1'b0;
      run(8);

      // Blank drop after beat 1, rise 10 cycles later.
      base = beats_issued;
      send_cmd(4, 5, 6, 7, 8, 'h00F);
      wait_beats(base + 2);
      blank = 1'b0;
      run(10);
      blank = 1'b1;
      run(8);

      // Bad index.
      base = dut_beats;
      send_cmd(NS, 1, 2, 3, 4, 5);
      run(4);
      chk("bad_no_beats", dut_beats - base, 0);

      // Reset after beat 2.
      base = beats_issued;
      send_cmd(1, 11, 22, 33, 44, 'h555);
      wait_beats(base + 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      base = dut_beats;
      run(10);
      chk("reset_no_more_beats", dut_beats - base, 0);

      // Same command twice, then colour only.
      base = dut_beats;
      send_cmd(5, 50, 60, 70, 80, 'h123);
      run(8);
      chk("repeat_first_count", dut_beats - base, 5);
      base = dut_beats;
      send_cmd(5, 50, 60, 70, 80, 'h123);
      run(8);
      chk("repeat_second_count", dut_beats - base, SHADOW ? 0 : 5);
      base = dut_beats;
      send_cmd(5, 50, 60, 70, 80, 'h321);
      run(8);
      chk("colour_only_count", dut_beats - base, SHADOW ? 1 : 5);
      chk("colour_only_reg", last_beat_y, 4);

      // Randomised traffic with repeated commands and rare resets.
      for (int i = 0; i < 500; i++) begin
         blank     = ($urandom_range(0, 9) < 7);
         pix_valid = ($urandom_range(0, 9) < 3);
         pix_x     = 11'($urandom_range(0, 2047));
         pix_y     = 12'($urandom_range(0, 4095));
         pix_data  = 12'($urandom_range(0, 4095));
         cmd_valid = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 2) != 0) begin
            rs = $urandom_range(0, 7);
            rf = '{$urandom_range(0, 2047), $urandom_range(0, 4095), $urandom_range(0, 2047),
                   $urandom_range(0, 4095), $urandom_range(0, 4095)};
            if ($urandom_range(0, 3) == 0) rf[4] = $urandom_range(0, 15);
         end
         cmd_shape  = SW'(rs);
         cmd_xcoord = 11'(rf[0]);
         cmd_ycoord = 12'(rf[1]);
         cmd_width  = 11'(rf[2]);
         cmd_height = 12'(rf[3]);
         cmd_color  = 12'(rf[4]);
         rst = ($urandom_range(0, 149) == 0);
         step();
      end

      // Drain.
      rst = 1'b0;
      cmd_valid = 1'b0;
      pix_valid = 1'b0;
      blank = 1'b1;
      run(20);
      chk("beat_queue_empty", beat_q.size(), 0);
      chk("pix_queue_empty", pix_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
